cc_obstacle_gen: RTL and testbench
==================================

Name: cc_obstacle_gen

Overview:
- Upstream producer of the obstacle bus consumed by the obstacle/point OR stage of the LED-matrix game.
- Holds an 8-row x 8-bit obstacle field that scrolls one row down per step tick.
- Injects new LFSR-based rows at the top, each with a 2-column hole.
- Exposes the selected row for the display scan, the bottom row for collision checking, and a score of cleared obstacle rows.

Parameters:
- NUMBER_DATAWIDTH, 8, row width in bits; fixed at 8.
- NUMBER_ROWS, 8, field depth; row 0 is the top row, row 7 is the bottom row.
- STEP_DIV, 25000000, clock cycles per scroll step; must be 4 or more.
- LFSR_SEED, 8'hA5, LFSR reset value; 8'h00 is replaced by 8'h01.
- GAP_ROWS, 2, number of blank rows inserted between consecutive obstacle rows.

Ports:
- CC_OBSGEN_CLOCK_50  in  1  system clock
- CC_OBSGEN_RESET_InHigh  in  1  asynchronous reset, active-high
- CC_OBSGEN_start_In  in  1  one-cycle start/restart pulse
- CC_OBSGEN_crash_In  in  1  collision flag from the downstream compare stage
- CC_OBSGEN_rowsel_InBUS  in  3  row index being scanned by the display
- CC_OBSGEN_obs_OutBUS  out  8  row[rowsel], combinational read
- CC_OBSGEN_bottom_OutBUS  out  8  row[7], registered
- CC_OBSGEN_step_Out  out  1  one-cycle pulse on each scroll step
- CC_OBSGEN_state_OutBUS  out  2  current state: 00 IDLE, 01 RUN, 10 OVER
- CC_OBSGEN_score_OutBUS  out  8  count of obstacle rows that exited the bottom, saturating

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - all rows 8'h00
  - LFSR = LFSR_SEED
  - step counter 0
  - gap counter 0
  - state IDLE
  - score 0
  - step_Out 0
  - bottom_OutBUS 8'h00
- IDLE:
  - field, counter and score are held.
  - start -> RUN on the next edge; the step counter is cleared.
- RUN:
  - The step counter increments every cycle.
  - At STEP_DIV-1 it wraps to 0, and step_Out is asserted for exactly that cycle.
  - First step occurs STEP_DIV cycles after the edge that entered RUN.
  - start is ignored while in RUN.
- Step action, all in the same edge:
  - row[i] <= row[i-1] for i = 7 down to 1.
  - row[0] <= new row.
  - The LFSR advances.
  - If the exiting row[7] is nonzero, score increments; it saturates at 255 and never wraps.
- New row generation:
  - If gap_cnt < GAP_ROWS: new row = 8'h00 and gap_cnt increments.
  - Otherwise: new row = 8'hFF with bits h and (h+1) mod 8 cleared, where h = LFSR[2:0], and gap_cnt resets to 0.
  - Wrap-around case: h = 7 clears bits 7 and 0 (8'h7E).
- LFSR:
  - 8-bit Fibonacci; shifts left by one bit per step.
  - Feedback into bit 0 = b7^b5^b4^b3.
  - The all-zero state is unreachable.
- Crash in RUN:
  - -> OVER on the next edge.
  - If crash and step coincide, crash wins: no shift, no score change, and step_Out is not asserted.
- OVER:
  - field, LFSR and score are frozen.
  - step_Out stays 0 and the counter holds.
  - start -> clears all rows, gap_cnt and score; clears the counter; state -> RUN. The LFSR is not reseeded.
- crash outside RUN is ignored.
- start and crash in the same cycle:
  - in IDLE/OVER, start wins;
  - in RUN, crash wins.
- obs_OutBUS reflects row[rowsel] in every state, with no latency. bottom_OutBUS updates on the same edge as the shift.
- Reset mid-operation:
  - immediate return to all reset values, independent of the clock;
  - a step_Out pulse in progress is dropped.

Optional Feature:
- Macro name: CC_OBSGEN_SPEEDUP_EN.
- When defined:
  - A 2-bit speed level starts at 0 and increments each time score crosses a multiple of 16; it saturates at 3.
  - Effective step period = STEP_DIV >> level.
  - A level change takes effect at the next counter wrap.
  - The level clears on reset and on restart from OVER.
- When undefined: the step period is fixed at STEP_DIV, and no level logic is synthesized.

Test Plan:
- Reset, then idle for 20 cycles -> state 00, all rows 0, score 0, and step_Out never asserted.
- With STEP_DIV=4, GAP_ROWS=2, pulse start -> state 01 next cycle; step_Out pulses every 4 cycles. row[0] is 0 for steps 1-2; step 3 loads 8'hFF with the 2-bit hole at LFSR[2:0]. Check bits against a reference LFSR model seeded 8'hA5.
- Run 8 more steps -> the first obstacle row appears on bottom_OutBUS after 7 shifts and increments score to 1 when it exits; blank rows leave score unchanged.
- Force h=7 by seed choice -> new row equals 8'h7E.
- Assert crash on the same cycle as step_Out would fire -> no shift, score unchanged, state 10. Hold 20 cycles and confirm the field is frozen. Pulse start -> rows 0, score 0, state 01.
- Preload score to 255 via a long run -> further exits keep score at 255. Assert reset mid-RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cc_obstacle_gen.sv
// cc_obstacle_gen: 8-row scrolling obstacle field with LFSR hole rows, bottom-row tap and exit score.
// Define CC_OBSGEN_SPEEDUP_EN to shorten the step period as the score passes multiples of 16.
module cc_obstacle_gen #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int NUMBER_ROWS = 8,
  parameter int STEP_DIV = 25000000,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int GAP_ROWS = 2
) (
  input  logic                        CC_OBSGEN_CLOCK_50,
  input  logic                        CC_OBSGEN_RESET_InHigh,
  input  logic                        CC_OBSGEN_start_In,
  input  logic                        CC_OBSGEN_crash_In,
  input  logic [2:0]                  CC_OBSGEN_rowsel_InBUS,
  output logic [NUMBER_DATAWIDTH-1:0] CC_OBSGEN_obs_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0] CC_OBSGEN_bottom_OutBUS,
  output logic                        CC_OBSGEN_step_Out,
  output logic [1:0]                  CC_OBSGEN_state_OutBUS,
  output logic [7:0]                  CC_OBSGEN_score_OutBUS
);
  localparam int CW = $clog2(STEP_DIV);
  localparam int GW = $clog2(GAP_ROWS + 2);
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10} stateT;
  stateT state, stateNext;
  logic [NUMBER_DATAWIDTH-1:0] rows [NUMBER_ROWS];
  logic [NUMBER_DATAWIDTH-1:0] newRow;
  logic [2*NUMBER_DATAWIDTH-1:0] holeMask;
  logic [7:0] lfsr, score;
  logic [CW-1:0] cnt, wrapVal;
  logic [GW-1:0] gapCnt;
  logic step, restart;
`ifdef CC_OBSGEN_SPEEDUP_EN
  logic [1:0] level, levelNow;
  assign wrapVal = CW'(STEP_DIV >> levelNow) - 1'b1;
  // a new level is latched into the live period only when the counter wraps
  always_ff @(posedge CC_OBSGEN_CLOCK_50 or posedge CC_OBSGEN_RESET_InHigh)
    if (CC_OBSGEN_RESET_InHigh) begin
      level <= '0;
      levelNow <= '0;
    end else if (restart) begin
      level <= '0;
      levelNow <= '0;
    end else begin
      if (step && |rows[NUMBER_ROWS-1] && score[3:0] == 4'hF && score != 8'hFF && level != 2'd3)
        level <= level + 1'b1;
      if (state == RUN && cnt == wrapVal) levelNow <= level;
    end
`else
  assign wrapVal = CW'(STEP_DIV - 1);
`endif
  always_ff @(posedge CC_OBSGEN_CLOCK_50 or posedge CC_OBSGEN_RESET_InHigh)
    if (CC_OBSGEN_RESET_InHigh) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    step = 1'b0;
    restart = 1'b0;
    if (state == RUN) begin
      stateNext = CC_OBSGEN_crash_In ? OVER : RUN;
      step = !CC_OBSGEN_crash_In && cnt == wrapVal;
    end else if (CC_OBSGEN_start_In) begin
      stateNext = RUN;
      restart = state == OVER;
    end
  end
  // two set bits rotated by h give the hole, wrapping bit 7 around to bit 0
  assign holeMask = {{(2*NUMBER_DATAWIDTH-2){1'b0}}, 2'b11} << lfsr[2:0];
  assign newRow = gapCnt < GW'(GAP_ROWS) ? '0
                : ~(holeMask[NUMBER_DATAWIDTH-1:0] | holeMask[2*NUMBER_DATAWIDTH-1:NUMBER_DATAWIDTH]);
  always_ff @(posedge CC_OBSGEN_CLOCK_50 or posedge CC_OBSGEN_RESET_InHigh)
    if (CC_OBSGEN_RESET_InHigh) begin
      for (int i = 0; i < NUMBER_ROWS; i++) rows[i] <= '0;
      lfsr <= SEED;
      cnt <= '0;
      gapCnt <= '0;
      score <= '0;
    end else begin
      if (state == RUN) cnt <= cnt == wrapVal ? '0 : cnt + 1'b1;
      else if (CC_OBSGEN_start_In) cnt <= '0;
      if (restart) begin
        for (int i = 0; i < NUMBER_ROWS; i++) rows[i] <= '0;
        gapCnt <= '0;
        score <= '0;
      end else if (step) begin
        rows[0] <= newRow;
        for (int i = 1; i < NUMBER_ROWS; i++) rows[i] <= rows[i-1];
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        gapCnt <= gapCnt < GW'(GAP_ROWS) ? gapCnt + 1'b1 : '0;
        if (|rows[NUMBER_ROWS-1] && score != 8'hFF) score <= score + 1'b1;
      end
    end
  assign CC_OBSGEN_obs_OutBUS = rows[CC_OBSGEN_rowsel_InBUS];
  assign CC_OBSGEN_bottom_OutBUS = rows[NUMBER_ROWS-1];
  assign CC_OBSGEN_step_Out = step;
  assign CC_OBSGEN_state_OutBUS = state;
  assign CC_OBSGEN_score_OutBUS = score;
endmodule

// File: tb/tb_cc_obstacle_gen.sv
// tb_cc_obstacle_gen: random-stimulus bench for cc_obstacle_gen against a queue-based field model.
module tb_cc_obstacle_gen;
  localparam int STEP_DIV = 4;
  localparam int GAP_ROWS = 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, crash = 1'b0, start2 = 1'b0;
  logic [2:0] rowsel = '0;
  logic [7:0] obs, bottom, score, obs2, bottom2, score2;
  logic [1:0] state, state2;
  logic step, step2;
  int nCmp = 0, nBad = 0;
  // model: field as a queue (index 0 = top), run phase, LFSR, gap count, score, steps taken
  logic [7:0] mRows [$];
  logic [7:0] mLfsr;
  int mState, mPhase, mGap, mScore, mSteps;

  always #10 clk = ~clk;

  cc_obstacle_gen #(.STEP_DIV(STEP_DIV), .GAP_ROWS(GAP_ROWS), .LFSR_SEED(8'hA5)) dut (
    .CC_OBSGEN_CLOCK_50(clk), .CC_OBSGEN_RESET_InHigh(rst), .CC_OBSGEN_start_In(start),
    .CC_OBSGEN_crash_In(crash), .CC_OBSGEN_rowsel_InBUS(rowsel), .CC_OBSGEN_obs_OutBUS(obs),
    .CC_OBSGEN_bottom_OutBUS(bottom), .CC_OBSGEN_step_Out(step), .CC_OBSGEN_state_OutBUS(state),
    .CC_OBSGEN_score_OutBUS(score));

  // seed 8'h85 puts LFSR[2:0] = 7 at the first obstacle row
  cc_obstacle_gen #(.STEP_DIV(STEP_DIV), .GAP_ROWS(GAP_ROWS), .LFSR_SEED(8'h85)) dut2 (
    .CC_OBSGEN_CLOCK_50(clk), .CC_OBSGEN_RESET_InHigh(rst), .CC_OBSGEN_start_In(start2),
    .CC_OBSGEN_crash_In(1'b0), .CC_OBSGEN_rowsel_InBUS(3'd0), .CC_OBSGEN_obs_OutBUS(obs2),
    .CC_OBSGEN_bottom_OutBUS(bottom2), .CC_OBSGEN_step_Out(step2), .CC_OBSGEN_state_OutBUS(state2),
    .CC_OBSGEN_score_OutBUS(score2));

  function automatic logic [7:0] holeRow(input logic [2:0] h);
    logic [7:0] r;
    r = 8'hFF;
    r[h] = 1'b0;
    r[h + 3'd1] = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] lfsrNext(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic bit expStep(input logic cr);
    return mState == 1 && mPhase == STEP_DIV - 1 && !cr;
  endfunction

  task automatic modelReset();
    mRows.delete();
    repeat (8) mRows.push_back(8'h00);
    mLfsr = 8'hA5;
    mState = 0; mPhase = 0; mGap = 0; mScore = 0; mSteps = 0;
  endtask

  task automatic modelStep();
    logic [7:0] nr, ex;
    if (mGap < GAP_ROWS) begin
      nr = 8'h00;
      mGap++;
    end else begin
      nr = holeRow(mLfsr[2:0]);
      mGap = 0;
    end
    mLfsr = lfsrNext(mLfsr);
    mRows.push_front(nr);
    ex = mRows.pop_back();
    if (ex != 8'h00 && mScore < 255) mScore++;
    mSteps++;
  endtask

  task automatic modelEdge(input logic st, input logic cr);
    case (mState)
      0: if (st) begin mState = 1; mPhase = 0; end
      1: if (cr) mState = 2;
         else if (mPhase == STEP_DIV - 1) begin mPhase = 0; modelStep(); end
         else mPhase++;
      default: if (st) begin
        mState = 1; mPhase = 0; mGap = 0; mScore = 0; mSteps = 0;
        for (int r = 0; r < 8; r++) mRows[r] = 8'h00;
      end
    endcase
  endtask

  task automatic drive(input logic st, input logic cr);
    @(negedge clk);
    start = st; crash = cr; rowsel = 3'($urandom_range(0, 7));
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    modelEdge(start, crash);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; crash = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    nCmp++; if (state !== 2'b00 || score !== 8'h00 || step !== 1'b0 || bottom !== 8'h00) begin
      nBad++; $display("FAIL reset_values state=%b score=%0d step=%b bottom=%h want 00/0/0/00", state, score, step, bottom); end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'($urandom_range(0, 1)));
      nCmp++; if (state !== 2'b00) begin nBad++; $display("FAIL idle_state got %b want 00", state); end
      nCmp++; if (step !== 1'b0) begin nBad++; $display("FAIL idle_step got %b want 0", step); end
      nCmp++; if (score !== 8'h00) begin nBad++; $display("FAIL idle_score got %0d want 0", score); end
      for (int r = 0; r < 8; r++) begin
        rowsel = 3'(r); #1;
        nCmp++; if (obs !== 8'h00) begin nBad++; $display("FAIL idle_row%0d got %h want 00", r, obs); end
      end
      advance();
    end
  endtask

  task automatic test_steps();
    int nSteps = 0;
    drive(1'b1, 1'b0);
    advance();
    for (int c = 0; c < 3 * STEP_DIV; c++) begin
      drive(1'($urandom_range(0, 1)), 1'b0);
      nCmp++; if (state !== 2'b01) begin nBad++; $display("FAIL run_state c=%0d got %b want 01", c, state); end
      nCmp++; if (step !== ((c % STEP_DIV) == STEP_DIV - 1)) begin
        nBad++; $display("FAIL step_period c=%0d got %b want %b", c, step, (c % STEP_DIV) == STEP_DIV - 1); end
      nCmp++; if (obs !== mRows[rowsel]) begin nBad++; $display("FAIL steps_obs row%0d got %h want %h", rowsel, obs, mRows[rowsel]); end
      if (step === 1'b1) nSteps++;
      advance();
    end
    drive(1'b0, 1'b0);
    nCmp++; if (nSteps != 3) begin nBad++; $display("FAIL step_count got %0d want 3", nSteps); end
    rowsel = 3'd0; #1;
    nCmp++; if (obs !== 8'h9F) begin nBad++; $display("FAIL first_obstacle got %h want 9f", obs); end
    for (int r = 1; r < 3; r++) begin
      rowsel = 3'(r); #1;
      nCmp++; if (obs !== 8'h00) begin nBad++; $display("FAIL gap_row%0d got %h want 00", r, obs); end
    end
    advance();
  endtask

  task automatic test_scroll();
    int c = 0;
    while (mSteps < 11 && c < 80) begin
      drive(1'b0, 1'b0);
      nCmp++; if (step !== expStep(1'b0)) begin nBad++; $display("FAIL scroll_step got %b want %b", step, expStep(1'b0)); end
      nCmp++; if (bottom !== mRows[7]) begin nBad++; $display("FAIL scroll_bottom got %h want %h", bottom, mRows[7]); end
      if (mSteps == 10) begin
        nCmp++; if (bottom !== 8'h9F) begin nBad++; $display("FAIL obstacle_at_bottom got %h want 9f", bottom); end
      end
      nCmp++; if (score !== 8'h00) begin nBad++; $display("FAIL blank_exit_score got %0d want 0", score); end
      advance();
      c++;
    end
    drive(1'b0, 1'b0);
    nCmp++; if (mSteps != 11) begin nBad++; $display("FAIL scroll_timeout steps=%0d want 11", mSteps); end
    nCmp++; if (score !== 8'd1) begin nBad++; $display("FAIL first_exit_score got %0d want 1", score); end
    nCmp++; if (bottom !== mRows[7]) begin nBad++; $display("FAIL exit_bottom got %h want %h", bottom, mRows[7]); end
    advance();
  endtask

  task automatic test_wrap_hole();
    int seen = 0;
    bit done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      start2 = (c == 0);
      drive(1'b0, 1'b0);
      nCmp++; if (obs !== mRows[rowsel]) begin nBad++; $display("FAIL wrap_main_obs got %h want %h", obs, mRows[rowsel]); end
      advance();
      #6;
      if (seen == 3) begin
        nCmp++; if (obs2 !== 8'h7E) begin nBad++; $display("FAIL wrap_hole got %h want 7e", obs2); end
        nCmp++; if (state2 !== 2'b01) begin nBad++; $display("FAIL wrap_state got %b want 01", state2); end
        done = 1'b1;
      end else if (step2 === 1'b1) seen++;
    end
    start2 = 1'b0;
    nCmp++; if (!done) begin nBad++; $display("FAIL wrap_timeout steps_seen=%0d want 3", seen); end
  endtask

  task automatic test_crash_on_step();
    logic [7:0] snap [8];
    int snapScore;
    for (int c = 0; c < 2 * STEP_DIV && mPhase != STEP_DIV - 1; c++) begin drive(1'b0, 1'b0); advance(); end
    drive(1'b0, 1'b1);
    nCmp++; if (mPhase != STEP_DIV - 1) begin nBad++; $display("FAIL crash_align phase=%0d want %0d", mPhase, STEP_DIV - 1); end
    nCmp++; if (step !== 1'b0) begin nBad++; $display("FAIL crash_step got %b want 0", step); end
    for (int r = 0; r < 8; r++) snap[r] = mRows[r];
    snapScore = mScore;
    advance();
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'($urandom_range(0, 1)));
      nCmp++; if (state !== 2'b10) begin nBad++; $display("FAIL over_state got %b want 10", state); end
      nCmp++; if (step !== 1'b0) begin nBad++; $display("FAIL over_step got %b want 0", step); end
      nCmp++; if (score !== 8'(snapScore)) begin nBad++; $display("FAIL over_score got %0d want %0d", score, snapScore); end
      for (int r = 0; r < 8; r++) begin
        rowsel = 3'(r); #1;
        nCmp++; if (obs !== snap[r]) begin nBad++; $display("FAIL frozen_row%0d got %h want %h", r, obs, snap[r]); end
      end
      advance();
    end
    drive(1'b1, 1'b1);
    advance();
    drive(1'b0, 1'b0);
    nCmp++; if (state !== 2'b01) begin nBad++; $display("FAIL restart_state got %b want 01", state); end
    nCmp++; if (score !== 8'h00) begin nBad++; $display("FAIL restart_score got %0d want 0", score); end
    for (int r = 0; r < 8; r++) begin
      rowsel = 3'(r); #1;
      nCmp++; if (obs !== 8'h00) begin nBad++; $display("FAIL restart_row%0d got %h want 00", r, obs); end
    end
    advance();
  endtask

  task automatic test_random_crash();
    int len;
    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(3, 30);
      for (int c = 0; c < len; c++) begin
        drive(1'($urandom_range(0, 1)), 1'b0);
        nCmp++; if (state !== 2'(mState)) begin nBad++; $display("FAIL rnd_state got %b want %0d", state, mState); end
        nCmp++; if (step !== expStep(1'b0)) begin nBad++; $display("FAIL rnd_step got %b want %b", step, expStep(1'b0)); end
        nCmp++; if (obs !== mRows[rowsel]) begin nBad++; $display("FAIL rnd_obs row%0d got %h want %h", rowsel, obs, mRows[rowsel]); end
        advance();
      end
      drive(1'($urandom_range(0, 1)), 1'b1);
      nCmp++; if (step !== 1'b0) begin nBad++; $display("FAIL rnd_crash_step got %b want 0", step); end
      advance();
      len = $urandom_range(2, 6);
      for (int c = 0; c < len; c++) begin
        drive(1'b0, 1'($urandom_range(0, 1)));
        nCmp++; if (state !== 2'b10) begin nBad++; $display("FAIL rnd_over_state got %b want 10", state); end
        nCmp++; if (score !== 8'(mScore)) begin nBad++; $display("FAIL rnd_over_score got %0d want %0d", score, mScore); end
        nCmp++; if (obs !== mRows[rowsel]) begin nBad++; $display("FAIL rnd_over_obs got %h want %h", obs, mRows[rowsel]); end
        advance();
      end
      drive(1'b1, 1'($urandom_range(0, 1)));
      advance();
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 3600; c++) begin
      drive(1'b0, 1'b0);
      nCmp++; if (score !== 8'(mScore)) begin nBad++; $display("FAIL sat_score c=%0d got %0d want %0d", c, score, mScore); end
      nCmp++; if (step !== expStep(1'b0)) begin nBad++; $display("FAIL sat_step got %b want %b", step, expStep(1'b0)); end
      nCmp++; if (bottom !== mRows[7]) begin nBad++; $display("FAIL sat_bottom got %h want %h", bottom, mRows[7]); end
      if (expStep(1'b0))
        for (int r = 0; r < 8; r++) begin
          rowsel = 3'(r); #1;
          nCmp++; if (obs !== mRows[r]) begin nBad++; $display("FAIL sat_row%0d got %h want %h", r, obs, mRows[r]); end
        end
      advance();
    end
    drive(1'b0, 1'b0);
    nCmp++; if (score !== 8'hFF) begin nBad++; $display("FAIL score_saturate got %0d want 255", score); end
    advance();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2 * STEP_DIV && !(mState == 1 && mPhase == STEP_DIV - 1); c++) begin drive(1'b0, 1'b0); advance(); end
    @(negedge clk);
    start = 1'b0; crash = 1'b0;
    #1;
    nCmp++; if (step !== 1'b1) begin nBad++; $display("FAIL pre_reset_step got %b want 1", step); end
    #2 rst = 1'b1;
    #1;
    nCmp++; if (state !== 2'b00) begin nBad++; $display("FAIL async_state got %b want 00", state); end
    nCmp++; if (step !== 1'b0) begin nBad++; $display("FAIL async_step got %b want 0", step); end
    nCmp++; if (score !== 8'h00) begin nBad++; $display("FAIL async_score got %0d want 0", score); end
    nCmp++; if (bottom !== 8'h00) begin nBad++; $display("FAIL async_bottom got %h want 00", bottom); end
    for (int r = 0; r < 8; r++) begin
      rowsel = 3'(r); #1;
      nCmp++; if (obs !== 8'h00) begin nBad++; $display("FAIL async_row%0d got %h want 00", r, obs); end
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    drive(1'b0, 1'b0);
    nCmp++; if (state !== 2'b00 || score !== 8'h00) begin nBad++; $display("FAIL post_reset state=%b score=%0d want 00/0", state, score); end
    advance();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_steps();
    test_scroll();
    test_wrap_hole();
    test_crash_on_step();
    test_random_crash();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
